scan_sequencer_2to4: RTL

Channel scan sequencer that drives the enable and 2-bit select inputs of the 2-to-4 decoder stage. On a start request it steps through the enabled channels of a 4-bit mask in ascending order, holding each channel's select code with enable asserted for a programmable dwell time. It then signals completion. It sits directly upstream of the decoder: its `en`, `a` and `b` outputs wire straight to the decoder's inputs of the same names.

---
 rtl/scan_sequencer_2to4_if.sv | 26 ++
 rtl/scan_sequencer_2to4.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/scan_sequencer_2to4_if.sv
// Control/status bundle between a scan host and scan_sequencer_2to4.
// The host drives the sweep request side; the sequencer drives the decoder-facing outputs.
interface scan_sequencer_2to4_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               cont;
    logic [3:0]         chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic               en;
    logic               a;
    logic               b;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, cont, chan_mask, dwell,
        input  en, a, b, busy, done
    );

    modport slave (
        input  start, stop, cont, chan_mask, dwell,
        output en, a, b, busy, done
    );
endinterface

// File: rtl/scan_sequencer_2to4.sv
// Channel scan sequencer feeding the en/a/b inputs of a 2-to-4 decoder.
// Define SCAN_SEQUENCER_CONTINUOUS_EN to let a captured cont=1 wrap the sweep until stop.
//
// state  | meaning
// IDLE   | waiting for start; captures mask/dwell/cont when it arrives
// ACTIVE | en high, {b,a} = current channel, dwell counter running
// DONE   | one-cycle done pulse, then back to IDLE
module scan_sequencer_2to4 #(
    parameter int DWELL_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    scan_sequencer_2to4_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

`ifdef SCAN_SEQUENCER_CONTINUOUS_EN
    localparam logic CONT_ALLOWED = 1'b1;
`else
    localparam logic CONT_ALLOWED = 1'b0;
`endif

    state_t             state, state_nxt;
    logic [1:0]         ch, ch_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [3:0]         mask_q, mask_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic               cont_q, cont_nxt;
    logic               cont_in;
    logic [2:0]         higher;
    logic               en_d, busy_d, done_d;
    logic [1:0]         sel_d;
    logic               en_q, busy_q, done_q;
    logic [1:0]         sel_q;

    assign cont_in = bus.cont & CONT_ALLOWED;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // {found, channel} of the nearest enabled channel above cur
    function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ch      <= 2'd0;
            cnt     <= '0;
            mask_q  <= 4'd0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            en_q    <= 1'b0;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch      <= ch_nxt;
            cnt     <= cnt_nxt;
            mask_q  <= mask_nxt;
            dwell_q <= dwell_nxt;
            cont_q  <= cont_nxt;
            en_q    <= en_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        cnt_nxt   = cnt;
        mask_nxt  = mask_q;
        dwell_nxt = dwell_q;
        cont_nxt  = cont_q;
        higher    = 3'b000;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    mask_nxt  = bus.chan_mask;
                    dwell_nxt = bus.dwell;
                    cont_nxt  = cont_in;
                    if (|bus.chan_mask) begin
                        ch_nxt    = lowest_ch(bus.chan_mask);
                        cnt_nxt   = bus.dwell;
                        state_nxt = ST_ACTIVE;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (bus.stop) begin
                    state_nxt = ST_DONE;
                end else if (cnt == '0) begin
                    higher = next_ch(mask_q, ch);
                    if (higher[2]) begin
                        ch_nxt  = higher[1:0];
                        cnt_nxt = dwell_q;
                    end else if (cont_q) begin
                        ch_nxt  = lowest_ch(mask_q);
                        cnt_nxt = dwell_q;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    cnt_nxt = cnt - DWELL_W'(1);
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops
    always_comb begin
        en_d   = (state_nxt == ST_ACTIVE);
        busy_d = (state_nxt == ST_ACTIVE);
        done_d = (state_nxt == ST_DONE);
        sel_d  = (state_nxt == ST_ACTIVE) ? ch_nxt : 2'd0;
    end

    assign bus.en   = en_q;
    assign bus.a    = sel_q[0];
    assign bus.b    = sel_q[1];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
